logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one bitwise logic unit among NUM_REQ requesters; the unit supports AND, OR, XOR, NOT A, NOT B, NAND, NOR and XNOR.
- Round-robin arbitration, valid/ready request handshake, registered result returned on a single response channel tagged with the requester ID.
- Sits between requester blocks and the shared gate datapath.
- Sequences operand capture, evaluation and response back-pressure.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 8, operand/result width in bits.
- ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden).

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  synchronous active-high reset.
- req_valid_in  input  NUM_REQ  per-requester request valid.
- req_ready_out  output  NUM_REQ  per-requester accept strobe (at most one bit high).
- req_op_in  input  3*NUM_REQ  op code per requester; requester i uses bits [3i+2:3i].
- req_a_in  input  WIDTH*NUM_REQ  operand A per requester, slice i.
- req_b_in  input  WIDTH*NUM_REQ  operand B per requester, slice i.
- rsp_valid_out  output  1  response valid.
- rsp_ready_in  input  1  response consumer ready.
- rsp_id_out  output  ID_W  index of requester owning the response.
- rsp_data_out  output  WIDTH  operation result.
- busy_out  output  1  high when not in IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_in, rst_in).
- Reset values: state=IDLE, rr_ptr=0, rsp_valid_out=0, rsp_id_out=0, rsp_data_out=0, busy_out=0. req_ready_out=0 while rst_in is high.
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 ~A, 4 ~B, 5 NAND, 6 NOR, 7 XNOR. All ops are bitwise over WIDTH bits.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid_in bit is set, grant the first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - req_ready_out[g]=1 combinationally in that cycle; this is the accept.
  - On the clock edge: latch op, A, B and g; set rr_ptr=(g+1) mod NUM_REQ; go to EXEC.
  - If no request is valid, stay in IDLE; req_ready_out=0.
- EXEC (1 cycle): compute from the latched operands; register the result into rsp_data_out and g into rsp_id_out; set rsp_valid_out=1; go to RESP.
- RESP:
  - Hold rsp_valid_out, rsp_id_out and rsp_data_out stable until rsp_valid_out & rsp_ready_in.
  - On that edge: clear rsp_valid_out and return to IDLE. rsp_data_out and rsp_id_out keep their last values.
  - No requests are accepted in EXEC or RESP; req_ready_out=0.
- Latency: accept edge to rsp_valid_out high = 2 cycles. Best-case throughput is one operation per 3 cycles (rsp_ready_in held high).
- busy_out=1 in EXEC and RESP.
- Requester rules:
  - Once asserted, req_valid_in and that requester's op/operands must stay stable until req_ready_out for it is seen.
  - Requesters must not make valid depend on ready. The block may make ready depend on valid.
- Fairness: a requester that holds valid is granted within NUM_REQ grants.
- Single requester: the pointer advances past it, the search wraps, and it is re-granted.
- Simultaneous events:
  - Multiple valids in the same cycle are resolved purely by rr_ptr.
  - A request arriving during RESP waits; it is eligible in the first IDLE cycle.
- Reset mid-operation: an in-flight operation is discarded with no response; the pointer returns to 0.
- Invalid config: unused op codes do not exist (3 bits fully decoded). The result is never X for known inputs.

Test Plan:
- Reset, then req0 valid with op=0, A=8'hF0, B=8'h3C, rsp_ready_in=1 -> req_ready_out=4'b0001 in the accept cycle. 2 cycles later rsp_valid_out=1, rsp_id_out=0, rsp_data_out=8'h30. Next cycle rsp_valid_out=0.
- Sweep all 8 ops on requester 2 with A=8'hA5, B=8'h0F -> results 05, AF, AA, 5A, F0, FA, 50, 55, each with rsp_id_out=2.
- All 4 requesters valid continuously, rsp_ready_in=1 -> grants in order 0,1,2,3,0,... Every 4th grant returns to the same requester; no requester is skipped.
- Back-pressure: rsp_ready_in=0 for 5 cycles after rsp_valid_out rises -> rsp_valid_out, rsp_id_out and rsp_data_out stay constant. req_ready_out stays 0 and busy_out stays 1. Release gives one handshake, then IDLE.
- rst_in asserted during EXEC with req1 granted -> next cycle state=IDLE, rsp_valid_out=0 and no response is ever emitted. After reset, req1 and req3 both valid -> req1 is granted first (rr_ptr=0).
- rr_ptr=3 with only req0 and req3 valid -> req3 is granted, then req0, then req3.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one bitwise logic unit among NUM_REQ requesters.
// Requesters are picked round-robin in IDLE. The winner's operands are evaluated
// in EXEC. The tagged result is then held in RESP until the consumer takes it.
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [3*NUM_REQ-1:0]     req_op_in,
  input  logic [WIDTH*NUM_REQ-1:0] req_a_in,
  input  logic [WIDTH*NUM_REQ-1:0] req_b_in,
  output logic                     rsp_valid_out,
  input  logic                     rsp_ready_in,
  output logic [ID_W-1:0]          rsp_id_out,
  output logic [WIDTH-1:0]         rsp_data_out,
  output logic                     busy_out
);

  localparam int OP_W   = 3;
  localparam int SCAN_W = ID_W + 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   grant_id_r;
  logic [OP_W-1:0]   op_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;

  logic              grant_found_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic [SCAN_W-1:0] scan_sum_s;
  logic [ID_W-1:0]   scan_idx_s;
  logic [OP_W-1:0]   sel_op_s;
  logic [WIDTH-1:0]  sel_a_s;
  logic [WIDTH-1:0]  sel_b_s;

  // The eight bitwise operations; all 3-bit codes are decoded.
  function automatic logic [WIDTH-1:0] logic_eval(
    input logic [OP_W-1:0]  op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    case (op)
      3'd0:    res = a & b;
      3'd1:    res = a | b;
      3'd2:    res = a ^ b;
      3'd3:    res = ~a;
      3'd4:    res = ~b;
      3'd5:    res = ~(a & b);
      3'd6:    res = ~(a | b);
      3'd7:    res = ~(a ^ b);
      default: res = '0;
    endcase
    return res;
  endfunction

  // Round-robin search: first valid requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    scan_sum_s    = '0;
    scan_idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum_s = {1'b0, rr_ptr_r} + SCAN_W'(k);
      scan_sum_s = (scan_sum_s >= SCAN_W'(NUM_REQ)) ? (scan_sum_s - SCAN_W'(NUM_REQ)) : scan_sum_s;
      scan_idx_s = scan_sum_s[ID_W-1:0];
      if (!grant_found_s && req_valid_in[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Route the granted requester's op code and operands toward the capture registers.
  always_comb begin
    sel_op_s = req_op_in[OP_W*int'(grant_idx_s) +: OP_W];
    sel_a_s  = req_a_in[WIDTH*int'(grant_idx_s) +: WIDTH];
    sel_b_s  = req_b_in[WIDTH*int'(grant_idx_s) +: WIDTH];
  end

  // Accept strobe: only in IDLE, only for the search winner, never during reset.
  always_comb begin
    req_ready_out = '0;
    if (!rst_in && (state_r == IDLE) && grant_found_s) begin
      req_ready_out[grant_idx_s] = 1'b1;
    end else begin
      req_ready_out = '0;
    end
  end

  // Sequencing FSM: capture on accept, evaluate once, hold the response until it is taken.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      grant_id_r    <= '0;
      op_r          <= '0;
      a_r           <= '0;
      b_r           <= '0;
      rsp_valid_out <= 1'b0;
      rsp_id_out    <= '0;
      rsp_data_out  <= '0;
      busy_out      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            op_r       <= sel_op_s;
            a_r        <= sel_a_s;
            b_r        <= sel_b_s;
            grant_id_r <= grant_idx_s;
            rr_ptr_r   <= (grant_idx_s == LAST_ID) ? '0 : (grant_idx_s + ID_W'(1'b1));
            busy_out   <= 1'b1;
            state_r    <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_out  <= logic_eval(op_r, a_r, b_r);
          rsp_id_out    <= grant_id_r;
          rsp_valid_out <= 1'b1;
          state_r       <= RESP;
        end
        RESP: begin
          if (rsp_valid_out && rsp_ready_in) begin
            rsp_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            state_r       <= IDLE;
          end
        end
        default: begin
          rsp_valid_out <= 1'b0;
          busy_out      <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference (round-robin pick by modular search, truth-table ops).
module tb_logic_unit_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     valid;
  logic [N-1:0]     ready;
  logic [3*N-1:0]   op;
  logic [W*N-1:0]   a;
  logic [W*N-1:0]   b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_data;
  logic             busy;

  int tests = 0;
  int fails = 0;

  // Per-op truth table indexed by {a_bit, b_bit}.
  logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011, 4'b0101, 4'b0111, 4'b0001, 4'b1001};

  // Reference state: arbitration pointer, phase (0 idle, 1 evaluating, 2 responding), pending job.
  int         m_ptr;
  int         m_phase;
  int         m_g;
  int         m_id;
  int         m_last_grant;
  logic [2:0] m_op;
  logic [W-1:0] m_a, m_b, m_data;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_valid_in  (valid),
    .req_ready_out (ready),
    .req_op_in     (op),
    .req_a_in      (a),
    .req_b_in      (b),
    .rsp_valid_out (rsp_valid),
    .rsp_ready_in  (rsp_ready),
    .rsp_id_out    (rsp_id),
    .rsp_data_out  (rsp_data),
    .busy_out      (busy)
  );

  function automatic logic [W-1:0] ref_op(input int code, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = tt[code];
    for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  function automatic int pick();
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = pick();
    if (!rst && m_phase == 0 && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int g;
    m_last_grant = -1;
    if (rst) begin
      m_ptr = 0; m_phase = 0; m_id = 0; m_data = '0;
    end else begin
      case (m_phase)
        0: begin
          g = pick();
          if (g >= 0) begin
            m_g = g; m_op = op[3*g +: 3]; m_a = a[W*g +: W]; m_b = b[W*g +: W];
            m_ptr = (g + 1) % N; m_phase = 1; m_last_grant = g;
          end
        end
        1: begin
          m_data = ref_op(int'(m_op), m_a, m_b); m_id = m_g; m_phase = 2;
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    valid[i] = 1'b1; op[3*i +: 3] = o; a[W*i +: W] = x; b[W*i +: W] = y;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
  endtask

  task automatic drain();
    valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 6 && m_phase != 0; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = '1; rsp_ready = 1'b0;
    tick(); tick(); #3;
    tests++; if (ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    tests++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    rst = 1'b0; valid = '0;
    tick();
  endtask

  task automatic test_basic();
    set_req(0, 3'd0, 8'hF0, 8'h3C); rsp_ready = 1'b1;
    #3;
    tests++; if (ready !== 4'b0001) begin fails++; $display("FAIL basic_accept: got %b want 0001", ready); end
    tick(); valid[0] = 1'b0; #3;
    tests++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL basic_exec: busy %b rsp_valid %b want 1 0", busy, rsp_valid); end
    tick(); #3;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h30) begin fails++; $display("FAIL basic_rsp: valid %b id %0d data %h want 1 0 30", rsp_valid, rsp_id, rsp_data); end
    tick(); #3;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_done: valid %b busy %b want 0 0", rsp_valid, busy); end
    tick();
  endtask

  task automatic test_op_sweep();
    logic [W-1:0] expv [8];
    expv = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'hF0, 8'hFA, 8'h50, 8'h55};
    rsp_ready = 1'b1;
    for (int o = 0; o < 8; o++) begin
      set_req(2, 3'(o), 8'hA5, 8'h0F);
      #3;
      tests++; if (ready !== 4'b0100) begin fails++; $display("FAIL sweep_accept op%0d: got %b want 0100", o, ready); end
      tick(); valid[2] = 1'b0; tick(); #3;
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== expv[o]) begin fails++; $display("FAIL sweep_rsp op%0d: valid %b id %0d data %h want 1 2 %h", o, rsp_valid, rsp_id, rsp_data, expv[o]); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int r;
    logic [W-1:0] e;
    rst = 1'b1; tick(); rst = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_req(i);
    for (int k = 0; k < 2*N; k++) begin
      r = k % N;
      e = ref_op(int'(op[3*r +: 3]), a[W*r +: W], b[W*r +: W]);
      #3;
      tests++; if (ready !== N'(1 << r)) begin fails++; $display("FAIL rr_grant #%0d: got %b want %b", k, ready, N'(1 << r)); end
      tick(); rand_req(r); tick(); #3;
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(r) || rsp_data !== e) begin fails++; $display("FAIL rr_rsp #%0d: valid %b id %0d data %h want 1 %0d %h", k, rsp_valid, rsp_id, rsp_data, r, e); end
      tick();
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    rand_req(1); rsp_ready = 1'b0;
    e = ref_op(int'(op[5:3]), a[15:8], b[15:8]);
    #3;
    tests++; if (ready !== 4'b0010) begin fails++; $display("FAIL bp_accept: got %b want 0010", ready); end
    tick(); valid[1] = 1'b0; tick(); rand_req(0);
    for (int j = 0; j < 5; j++) begin
      #3;
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== e) begin fails++; $display("FAIL bp_hold c%0d: valid %b id %0d data %h want 1 1 %h", j, rsp_valid, rsp_id, rsp_data, e); end
      tests++; if (ready !== 4'b0000 || busy !== 1'b1) begin fails++; $display("FAIL bp_blocked c%0d: ready %b busy %b want 0000 1", j, ready, busy); end
      tick();
    end
    rsp_ready = 1'b1; #3;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_release: valid %b want 1", rsp_valid); end
    tick(); #3;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ready !== 4'b0001) begin fails++; $display("FAIL bp_idle: valid %b busy %b ready %b want 0 0 0001", rsp_valid, busy, ready); end
    tick(); drain();
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] e;
    rsp_ready = 1'b1; rand_req(1); #3;
    tests++; if (ready !== 4'b0010) begin fails++; $display("FAIL rstmid_accept: got %b want 0010", ready); end
    tick(); valid = '0; rst = 1'b1; #3;
    tests++; if (ready !== 4'b0000 || busy !== 1'b1) begin fails++; $display("FAIL rstmid_exec: ready %b busy %b want 0000 1", ready, busy); end
    tick(); rst = 1'b0; #3;
    tests++; if (rsp_id !== 2'd0 || rsp_data !== 8'h00) begin fails++; $display("FAIL rstmid_regs: id %0d data %h want 0 00", rsp_id, rsp_data); end
    for (int j = 0; j < 4; j++) begin
      tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_silent c%0d: valid %b busy %b want 0 0", j, rsp_valid, busy); end
      tick(); #3;
    end
    tick();
    rand_req(1); rand_req(3);
    e = ref_op(int'(op[5:3]), a[15:8], b[15:8]);
    #3;
    tests++; if (ready !== 4'b0010) begin fails++; $display("FAIL rstmid_ptr0: got %b want 0010", ready); end
    tick(); valid[1] = 1'b0; tick(); #3;
    tests++; if (rsp_id !== 2'd1 || rsp_data !== e) begin fails++; $display("FAIL rstmid_rsp: id %0d data %h want 1 %h", rsp_id, rsp_data, e); end
    tick(); #3;
    tests++; if (ready !== 4'b1000) begin fails++; $display("FAIL rstmid_next: got %b want 1000", ready); end
    tick(); drain();
  endtask

  task automatic test_ptr_wrap();
    logic [N-1:0] want [5];
    want = '{4'b1000, 4'b0001, 4'b1000, 4'b1000, 4'b1000};
    rsp_ready = 1'b1; rand_req(2);
    tick(); drain();
    rand_req(0); rand_req(3);
    for (int k = 0; k < 5; k++) begin
      #3;
      tests++; if (ready !== want[k]) begin fails++; $display("FAIL wrap_grant #%0d: got %b want %b", k, ready, want[k]); end
      tick();
      if (k < 2 && m_last_grant >= 0) rand_req(m_last_grant);
      if (k >= 2) valid[0] = 1'b0;
      tick(); tick();
    end
    drain();
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    rst = 1'b1; valid = '0; tick(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if (!valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
      rsp_ready = 1'($urandom_range(0, 1));
      er = exp_ready();
      #3;
      tests++; if (ready !== er) begin fails++; $display("FAIL rand_ready c%0d: got %b want %b", c, ready, er); end
      tests++; if (rsp_valid !== (m_phase == 2) || busy !== (m_phase != 0)) begin fails++; $display("FAIL rand_status c%0d: valid %b busy %b phase %0d", c, rsp_valid, busy, m_phase); end
      if (m_phase == 2) begin
        tests++; if (rsp_id !== IDW'(m_id) || rsp_data !== m_data) begin fails++; $display("FAIL rand_rsp c%0d: id %0d data %h want %0d %h", c, rsp_id, rsp_data, m_id, m_data); end
      end
      tick();
      if (m_last_grant >= 0) valid[m_last_grant] = 1'b0;
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; valid = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b0;
    m_ptr = 0; m_phase = 0; m_g = 0; m_id = 0; m_last_grant = -1;
    m_op = '0; m_a = '0; m_b = '0; m_data = '0;
    test_reset();
    test_basic();
    test_op_sweep();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_ptr_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d tests so far", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
